// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package mul_div_unit_pkg;

    // Operation codes presented on op; 110/111 are illegal and complete as no-ops.
    localparam logic [2:0] MDU_OP_MULT  = 3'b000;
    localparam logic [2:0] MDU_OP_MULTU = 3'b001;
    localparam logic [2:0] MDU_OP_DIV   = 3'b010;
    localparam logic [2:0] MDU_OP_DIVU  = 3'b011;
    localparam logic [2:0] MDU_OP_MTHI  = 3'b100;
    localparam logic [2:0] MDU_OP_MTLO  = 3'b101;

    // Quotient reported for any divide by zero.
    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_t;

    // Two's-complement negate.
    function automatic logic [31:0] f_neg(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Magnitude of v when treated as signed (en=1), otherwise v unchanged.
    function automatic logic [31:0] f_abs(input logic [31:0] v, input logic en);
        return (en && v[31]) ? f_neg(v) : v;
    endfunction

endpackage

// File: rtl/mul_div_unit_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per i_step, sequenced by the parent.
// Latency: 32 steps after i_load; o_quot/o_rem valid once the parent has issued all steps.
// Backpressure: none; the parent holds i_divisor stable and owns all sequencing.
//
// Ports: clk/rst (async active-high), i_load (capture dividend, clear remainder),
//        i_step (one restoring step), i_dividend, i_divisor, o_quot, o_rem.
module div_core #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_dividend,
    input  logic [DATA_WIDTH-1:0] i_divisor,
    output logic [DATA_WIDTH-1:0] o_quot,
    output logic [DATA_WIDTH-1:0] o_rem
);

    logic [DATA_WIDTH-1:0] r_rem;
    logic [DATA_WIDTH-1:0] r_quo;
    logic [DATA_WIDTH:0]   w_shift;
    logic                  w_ge;

    // Partial remainder shifted left with the next dividend bit, which is taken
    // from the top of the quotient register as it shifts the dividend out.
    assign w_shift = {r_rem, r_quo[DATA_WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_divisor});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
        end else if (i_load) begin
            r_rem <= '0;
            r_quo <= i_dividend;
        end else if (i_step) begin
            // Remainder after a successful subtract is always below the divisor,
            // so a DATA_WIDTH-bit subtraction is exact.
            r_rem <= w_ge ? (w_shift[DATA_WIDTH-1:0] - i_divisor) : w_shift[DATA_WIDTH-1:0];
            r_quo <= {r_quo[DATA_WIDTH-2:0], w_ge};
        end
    end

    assign o_quot = r_quo;
    assign o_rem  = r_rem;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO; HI/LO are always visible.
// Latency: mul/div done after edge 34 from accept (edge 1); MTHI/MTLO/illegal after edge 1.
// Backpressure: req_ready only in IDLE without flush; flush aborts in flight, HI/LO untouched.
//
// Ports: clk, rst (async active-high), req_valid/req_ready handshake, op, src_a, src_b,
//        flush, busy, done (one-cycle pulse), hi, lo.
// Build option: MDU_FAST_MULT_EN -> MULT/MULTU use a native single-cycle multiply
//        and finish after edge 1; otherwise a 32-cycle shift-add with no multiply operator.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ITER_CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    input  logic                  flush,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);

`ifdef MDU_FAST_MULT_EN
    localparam bit FAST_MULT = 1'b1;
`else
    localparam bit FAST_MULT = 1'b0;
`endif

    mdu_state_t r_state;
    mdu_state_t w_state_nxt;

    logic [ITER_CNT_W-1:0]   r_cnt;
    logic                    r_is_div;
    logic                    r_neg_res;
    logic                    r_neg_rem;
    logic                    r_div_zero;
    logic [DATA_WIDTH-1:0]   r_opnd;      // |a| as multiplicand, or |b| as divisor
    logic [DATA_WIDTH-1:0]   r_prod_hi;
    logic [DATA_WIDTH-1:0]   r_prod_lo;   // starts as |b|, multiplier bits consumed from bit 0
    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;

    logic                    w_accept;
    logic                    w_is_mul;
    logic                    w_is_div;
    logic                    w_signed;
    logic [DATA_WIDTH-1:0]   w_abs_a;
    logic [DATA_WIDTH-1:0]   w_abs_b;
    logic [DATA_WIDTH:0]     w_mul_sum;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0]   w_quot;
    logic [DATA_WIDTH-1:0]   w_rem;
    logic [DATA_WIDTH-1:0]   w_quot_fix;
    logic [DATA_WIDTH-1:0]   w_rem_fix;

    assign req_ready = (r_state == IDLE) && !flush && !rst;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE) && !flush;
    assign hi        = r_hi;
    assign lo        = r_lo;

    assign w_accept = req_valid && req_ready;
    assign w_is_mul = (op == MDU_OP_MULT) || (op == MDU_OP_MULTU);
    assign w_is_div = (op == MDU_OP_DIV)  || (op == MDU_OP_DIVU);
    assign w_signed = (op == MDU_OP_MULT) || (op == MDU_OP_DIV);
    assign w_abs_a  = f_abs(src_a, w_signed);
    assign w_abs_b  = f_abs(src_b, w_signed);

    // Shift-add step: add the multiplicand when the current multiplier bit is set,
    // then shift the 65-bit {carry, hi, lo} right by one.
    assign w_mul_sum = {1'b0, r_prod_hi} + (r_prod_lo[0] ? {1'b0, r_opnd} : '0);

    assign w_prod     = {r_prod_hi, r_prod_lo};
    assign w_prod_fix = r_neg_res ? (~w_prod + 64'd1) : w_prod;
    // Negating |a| as the remainder restores src_a itself, so divide-by-zero
    // naturally leaves hi = src_a; only the quotient needs overriding.
    assign w_quot_fix = r_div_zero ? DIV_ZERO_QUOT : (r_neg_res ? f_neg(w_quot) : w_quot);
    assign w_rem_fix  = r_neg_rem ? f_neg(w_rem) : w_rem;

    div_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_div_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept && w_is_div),
        .i_step     ((r_state == RUN) && r_is_div),
        .i_dividend (w_abs_a),
        .i_divisor  (r_opnd),
        .o_quot     (w_quot),
        .o_rem      (w_rem)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_is_div || (w_is_mul && !FAST_MULT)) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                if (r_cnt == {ITER_CNT_W{1'b1}}) begin
                    w_state_nxt = FIX;
                end
            end
            FIX:     w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (flush && (r_state != IDLE)) begin
            w_state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_opnd     <= '0;
            r_prod_hi  <= '0;
            r_prod_lo  <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_is_div;
                        r_neg_res  <= w_signed && (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
                        r_neg_rem  <= w_signed && src_a[DATA_WIDTH-1];
                        r_div_zero <= (src_b == '0);
                        r_opnd     <= w_is_div ? w_abs_b : w_abs_a;
                        r_prod_hi  <= '0;
                        r_prod_lo  <= w_abs_b;
                        if (op == MDU_OP_MTHI) begin
                            r_hi <= src_a;
                        end
                        if (op == MDU_OP_MTLO) begin
                            r_lo <= src_a;
                        end
`ifdef MDU_FAST_MULT_EN
                        if (w_is_mul) begin
                            {r_hi, r_lo} <= {{DATA_WIDTH{w_signed && src_a[DATA_WIDTH-1]}}, src_a}
                                          * {{DATA_WIDTH{w_signed && src_b[DATA_WIDTH-1]}}, src_b};
                        end
`endif
                    end
                end
                RUN: begin
                    if (!flush) begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!r_is_div) begin
                            r_prod_hi <= w_mul_sum[DATA_WIDTH:1];
                            r_prod_lo <= {w_mul_sum[0], r_prod_lo[DATA_WIDTH-1:1]};
                        end
                    end
                end
                FIX: begin
                    // Results land on the edge entering DONE so hi/lo match the done pulse.
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_lo <= w_prod_fix[DATA_WIDTH-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
